demux_1ton_buffered: RTL and testbench
======================================

Name: demux_1toN_buffered

Overview:
- Converse of the N-to-1 select mux: routes one WIDTH-bit input word to one of SIZE output lanes, chosen by an encoded select.
- Each lane has a one-entry holding register with its own valid/ready handshake, so a stalled lane does not block traffic to other lanes once its word is accepted.
- Sits between a single producer and SIZE independent consumers, for example a fan-out stage feeding per-lane engines.
- Also used with the mux in Fmax loop-back wrappers.

Parameters:
- WIDTH, 4: data width per lane, in bits.
- SIZE, 8: number of output lanes. Must be at least 2.
- LOG_SIZE, derived localparam, not overridable: number of bits needed to represent SIZE-1 (3 for SIZE=8, 3 for SIZE=6). This is the width of in_sel.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_data  input  WIDTH  word to route
- in_sel  input  LOG_SIZE  encoded destination lane
- in_valid  input  1  producer has a word
- in_ready  output  1  block accepts the word this cycle (combinational)
- out_data  output  WIDTH*SIZE  lane i occupies bits [i*WIDTH +: WIDTH]
- out_valid  output  SIZE  lane i holds a valid word
- out_ready  input  SIZE  consumer i takes lane i's word this cycle
- err_badsel  output  1  registered one-cycle pulse: a word with in_sel >= SIZE was accepted and discarded
- busy  output  1  registered; high when any out_valid bit is set

Behaviour:
- Reset, asynchronous: all hold registers clear to 0, out_valid = 0, err_badsel = 0, busy = 0. Words held at reset assertion are lost. No transfer completes while reset is high.
- Lane capacity: lane_free[i] = !out_valid[i] || out_ready[i].
- in_ready:
  - If in_sel < SIZE, in_ready = lane_free[in_sel].
  - If in_sel >= SIZE, in_ready = 1, so the word is always discarded.
  - in_ready may depend on in_sel and out_ready combinationally. It never depends on in_valid.
- Accept: a word is accepted when in_valid && in_ready. At most one word is accepted per cycle.
- Load of lane s = in_sel (valid select): at the next edge, hold[s] <= in_data and out_valid[s] <= 1. Input-to-output latency is 1 cycle.
- Drain: for each lane i, out_valid[i] && out_ready[i] completes a transfer. If lane i is not loaded that cycle, out_valid[i] <= 0 at the next edge.
- Simultaneous drain and load on the same lane: the old word is consumed, the new word is loaded, and out_valid stays 1. This gives 1 word per cycle throughput per lane.
- Stalled lane: when out_ready[i] = 0 and out_valid[i] = 1:
  - hold[i] stays stable and out_valid[i] stays 1.
  - Input words targeting lane i see in_ready = 0 and must be held by the producer.
  - Words for other lanes still flow.
- Bad select: an accepted word with in_sel >= SIZE changes no lane state. err_badsel = 1 for exactly the following cycle. This can only occur when SIZE is not a power of two.
- out_data[i] always shows hold[i]. Its contents are meaningful only while out_valid[i] = 1. It is unchanged when the lane drains.
- busy <= next-state OR of out_valid, so busy aligns with out_valid.
- in_valid = 0: no lane loads and err_badsel = 0 next cycle.
- out_ready is don't-care for a lane with out_valid = 0.
- No internal combinational path from out_ready to out_valid or to out_data.

Test Plan:
- Reset then single word: in_data=4'hA, in_sel=3, in_valid=1, all out_ready=0 -> in_ready=1; next cycle out_valid=8'b0000_1000, lane 3 data=4'hA, busy=1; other lanes 0.
- Stall and backpressure: lane 3 full with out_ready[3]=0, present 4'h5 to sel=3 -> in_ready=0, lane 3 keeps 4'hA. Switch to sel=5 -> accepted, lane 5=4'h5 next cycle.
- Simultaneous drain and load: lane 2 holds 4'h1 with out_ready[2]=1, input 4'h2 to sel=2 -> in_ready=1; next cycle lane 2=4'h2, out_valid[2] stays 1. Back-to-back streaming 8 words to lane 2 gives 1 word per cycle.
- Sweep all lanes: sel=0..7 with data=sel, out_ready=0 -> after 8 cycles out_valid=8'hFF and out_data=32'h7654_3210. Raise all out_ready for 1 cycle -> out_valid=0, busy=0.
- Bad select (SIZE=6): in_sel=7, in_valid=1 -> in_ready=1, err_badsel=1 for one cycle, out_valid unchanged. in_sel=6 behaves the same.
- Reset mid-operation: lanes 1 and 4 full, assert reset asynchronously between edges -> out_valid=0, out_data=0, busy=0 immediately, with no edge needed.

Source files
------------

// File: rtl/demux_1ton_buffered.sv
// One-to-SIZE demultiplexer with a one-entry holding register per output lane.
// Each lane has its own valid/ready handshake, so a stalled lane only backpressures words aimed at it.
module demux_1ton_buffered #(
  parameter  int WIDTH    = 4,
  parameter  int SIZE     = 8,
  localparam int LOG_SIZE = $clog2(SIZE)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      in_data,
  input  logic [LOG_SIZE-1:0]   in_sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WIDTH*SIZE-1:0] out_data,
  output logic [SIZE-1:0]       out_valid,
  input  logic [SIZE-1:0]       out_ready,
  output logic                  err_badsel,
  output logic                  busy
);

  localparam logic [LOG_SIZE:0] SizeW = (LOG_SIZE + 1)'(SIZE);

  logic [SIZE-1:0][WIDTH-1:0] hold_q, hold_d;
  logic [SIZE-1:0]            valid_q, valid_d;
  logic                       err_q, err_d;
  logic                       busy_q, busy_d;

  logic [SIZE-1:0] laneFree;
  logic [SIZE-1:0] selHit;
  logic [SIZE-1:0] laneLoad;
  logic            selValid;
  logic            accept;

  // Select decode; selects beyond the last lane never hit and are always accepted for discard.
  always_comb begin
    selHit   = '0;
    selValid = ({1'b0, in_sel} < SizeW);
    for (int i = 0; i < SIZE; i++) begin
      selHit[i] = (in_sel == LOG_SIZE'(i));
    end
    laneFree = ~valid_q | out_ready;
    in_ready = (|(selHit & laneFree)) | ~selValid;
    accept   = in_valid & in_ready;
    laneLoad = accept ? selHit : '0;
  end

  // A lane stays full while stalled, refills on the same cycle it drains, and otherwise empties.
  always_comb begin
    hold_d  = hold_q;
    valid_d = valid_q;
    for (int i = 0; i < SIZE; i++) begin
      if (laneLoad[i]) begin
        hold_d[i]  = in_data;
        valid_d[i] = 1'b1;
      end else if (out_ready[i]) begin
        valid_d[i] = 1'b0;
      end
    end
    err_d  = accept & ~selValid;
    busy_d = |valid_d;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hold_q  <= '0;
      valid_q <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      hold_q  <= hold_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign out_data   = hold_q;
  assign out_valid  = valid_q;
  assign err_badsel = err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_demux_1ton_buffered.sv
// Directed bench for demux_1ton_buffered: an 8-lane instance for routing/backpressure
// and a 6-lane instance for discarding out-of-range selects.
module tb_demux_1ton_buffered;

  logic        clock = 1'b0;
  logic        reset = 1'b1;

  logic [3:0]  inData  = '0;
  logic [2:0]  inSel   = '0;
  logic        inValid = 1'b0;
  logic        inReady;
  logic [31:0] outData;
  logic [7:0]  outValid;
  logic [7:0]  outReady = '0;
  logic        errBadsel;
  logic        busy;

  logic [3:0]  inData6  = '0;
  logic [2:0]  inSel6   = '0;
  logic        inValid6 = 1'b0;
  logic        inReady6;
  logic [23:0] outData6;
  logic [5:0]  outValid6;
  logic [5:0]  outReady6 = '0;
  logic        errBadsel6;
  logic        busy6;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  demux_1ton_buffered #(.WIDTH(4), .SIZE(8)) dut (
    .clock(clock), .reset(reset),
    .in_data(inData), .in_sel(inSel), .in_valid(inValid), .in_ready(inReady),
    .out_data(outData), .out_valid(outValid), .out_ready(outReady),
    .err_badsel(errBadsel), .busy(busy)
  );

  demux_1ton_buffered #(.WIDTH(4), .SIZE(6)) dut6 (
    .clock(clock), .reset(reset),
    .in_data(inData6), .in_sel(inSel6), .in_valid(inValid6), .in_ready(inReady6),
    .out_data(outData6), .out_valid(outValid6), .out_ready(outReady6),
    .err_badsel(errBadsel6), .busy(busy6)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] sel, input logic [3:0] data,
                               input logic valid, input logic [7:0] ready);
    inSel    = sel;
    inData   = data;
    inValid  = valid;
    outReady = ready;
  endtask

  // Advance one edge and settle just after it, away from the active edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #12;
    checkOutput("reset outValid", 64'(outValid), 64'h0);
    checkOutput("reset outData", 64'(outData), 64'h0);
    checkOutput("reset busy", 64'(busy), 64'h0);
    checkOutput("reset err", 64'(errBadsel), 64'h0);
    reset = 1'b0;
    step();

    // Single word to lane 3.
    applyStimulus(3'd3, 4'hA, 1'b1, 8'h00);
    #1;
    checkOutput("single inReady", 64'(inReady), 64'h1);
    step();
    checkOutput("single outValid", 64'(outValid), 64'h08);
    checkOutput("single outData", 64'(outData), 64'h0000_A000);
    checkOutput("single busy", 64'(busy), 64'h1);

    // Lane 3 stalled: its word is refused, other lanes still accept.
    applyStimulus(3'd3, 4'h5, 1'b1, 8'h00);
    #1;
    checkOutput("stall inReady", 64'(inReady), 64'h0);
    step();
    checkOutput("stall outValid", 64'(outValid), 64'h08);
    checkOutput("stall lane3", 64'(outData[15:12]), 64'hA);
    applyStimulus(3'd5, 4'h5, 1'b1, 8'h00);
    #1;
    checkOutput("other lane inReady", 64'(inReady), 64'h1);
    step();
    checkOutput("other lane outValid", 64'(outValid), 64'h28);
    checkOutput("other lane outData", 64'(outData), 64'h0050_A000);

    // Drain everything; hold contents remain visible.
    applyStimulus(3'd0, 4'h0, 1'b0, 8'hFF);
    step();
    checkOutput("drain outValid", 64'(outValid), 64'h00);
    checkOutput("drain busy", 64'(busy), 64'h0);
    checkOutput("drain outData kept", 64'(outData), 64'h0050_A000);

    // Simultaneous drain and load on lane 2, then stream.
    applyStimulus(3'd2, 4'h1, 1'b1, 8'h00);
    step();
    checkOutput("lane2 first", 64'(outData), 64'h0050_A100);
    applyStimulus(3'd2, 4'h2, 1'b1, 8'h04);
    #1;
    checkOutput("drainload inReady", 64'(inReady), 64'h1);
    step();
    checkOutput("drainload outValid", 64'(outValid), 64'h04);
    checkOutput("drainload outData", 64'(outData), 64'h0050_A200);
    for (int k = 3; k <= 10; k++) begin
      applyStimulus(3'd2, 4'(k), 1'b1, 8'h04);
      #1;
      checkOutput("stream inReady", 64'(inReady), 64'h1);
      step();
      checkOutput("stream lane2", 64'(outData[11:8]), 64'(k));
      checkOutput("stream valid", 64'(outValid), 64'h04);
    end
    applyStimulus(3'd2, 4'h0, 1'b0, 8'h04);
    step();
    checkOutput("stream end outValid", 64'(outValid), 64'h00);
    checkOutput("stream end busy", 64'(busy), 64'h0);

    // Fill every lane with its own index.
    for (int s = 0; s < 8; s++) begin
      applyStimulus(3'(s), 4'(s), 1'b1, 8'h00);
      #1;
      checkOutput("sweep inReady", 64'(inReady), 64'h1);
      step();
    end
    applyStimulus(3'd0, 4'h0, 1'b0, 8'h00);
    checkOutput("sweep outValid", 64'(outValid), 64'hFF);
    checkOutput("sweep outData", 64'(outData), 64'h7654_3210);
    checkOutput("sweep busy", 64'(busy), 64'h1);
    applyStimulus(3'd0, 4'h0, 1'b0, 8'hFF);
    step();
    checkOutput("sweep drain outValid", 64'(outValid), 64'h00);
    checkOutput("sweep drain busy", 64'(busy), 64'h0);
    outReady = 8'h00;

    // Six-lane instance: out-of-range selects are accepted and flagged.
    inSel6 = 3'd1; inData6 = 4'h3; inValid6 = 1'b1;
    step();
    checkOutput("six load outValid", 64'(outValid6), 64'h02);
    checkOutput("six noerr", 64'(errBadsel6), 64'h0);
    #1;
    checkOutput("six stall inReady", 64'(inReady6), 64'h0);
    inSel6 = 3'd7; inData6 = 4'hF;
    #1;
    checkOutput("badsel7 inReady", 64'(inReady6), 64'h1);
    step();
    checkOutput("badsel7 err", 64'(errBadsel6), 64'h1);
    checkOutput("badsel7 outValid", 64'(outValid6), 64'h02);
    checkOutput("badsel7 outData", 64'(outData6), 64'h00_0030);
    inSel6 = 3'd6;
    #1;
    checkOutput("badsel6 inReady", 64'(inReady6), 64'h1);
    step();
    checkOutput("badsel6 err", 64'(errBadsel6), 64'h1);
    checkOutput("badsel6 outValid", 64'(outValid6), 64'h02);
    inValid6 = 1'b0;
    step();
    checkOutput("badsel pulse end", 64'(errBadsel6), 64'h0);
    checkOutput("six busy", 64'(busy6), 64'h1);

    // Asynchronous reset between edges with lanes 1 and 4 full.
    applyStimulus(3'd1, 4'h9, 1'b1, 8'h00);
    step();
    applyStimulus(3'd4, 4'hC, 1'b1, 8'h00);
    step();
    applyStimulus(3'd0, 4'h0, 1'b0, 8'h00);
    checkOutput("premid outValid", 64'(outValid), 64'h12);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("async outValid", 64'(outValid), 64'h00);
    checkOutput("async outData", 64'(outData), 64'h0);
    checkOutput("async busy", 64'(busy), 64'h0);
    checkOutput("async six outValid", 64'(outValid6), 64'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
